nnrv_exec_muldiv: RTL and testbench
===================================

Name: nnrv_exec_muldiv

Overview:
- Iterative multi-cycle execute unit for the RV64M/RV32M multiply/divide instructions.
- Sits beside the single-cycle ALU in the exec stage. It accepts one operation per valid/ready handshake, holds the pipeline via o_busy, and returns a registered result with the same rd-forwarding outputs as the ALU path.
- Supports 32-bit (W) operations and pipeline kill.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. When XLEN=32, i_op_32bit is ignored and treated as 0.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  request valid from decode
- i_op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_op_32bit  in  1  W variant: operate on low 32 bits, sign-extend result
- i_op1  in  XLEN  rs1 value (multiplicand / dividend)
- i_op2  in  XLEN  rs2 value (multiplier / divisor)
- i_rd  in  5  destination register
- i_rd_en  in  1  destination write enable
- i_kill  in  1  flush: abandon in-flight or offered request
- o_ready  out  1  unit idle, can accept
- o_busy  out  1  operation in flight (stall request to decode)
- o_rd_en  out  1  captured rd enable
- o_rd  out  5  captured rd
- o_rd_ready  out  1  one-cycle pulse, o_rd_reg valid
- o_rd_reg  out  XLEN  result

Behaviour:
- Reset: state IDLE; o_ready=1; o_busy=0; o_rd_en=0; o_rd=0; o_rd_ready=0; o_rd_reg=0; all internal registers cleared.
- States:
  - IDLE: o_ready=1.
  - CALC: iterating; o_busy=1.
  - FIX: sign correction and result select; o_busy=1.
- Accept: i_valid & o_ready & !i_kill at a rising edge.
  - Operands, op, 32-bit flag, rd and rd_en are latched; o_rd/o_rd_en update at this edge.
  - Default: IDLE->CALC, counter loaded with N (N=32 if i_op_32bit else XLEN).
  - Special case (divide with divisor==0, or signed divide overflow): IDLE->FIX, skipping CALC.
- CALC, one iteration per edge:
  - Multiply: radix-2 shift-add on magnitudes, 2N-bit product.
  - Divide: radix-2 restoring on magnitudes.
  - After N edges -> FIX.
- FIX edge: state->IDLE; o_rd_reg loaded; o_rd_ready=1 for exactly one cycle.
- Latency:
  - Normal: N+2 edges from accept to o_rd_ready, i.e. 66 for XLEN=64, 34 for W ops.
  - Special case: 2 edges.
- Back-to-back: o_ready=1 in the o_rd_ready cycle, so a new accept on that edge is legal. o_rd_reg holds until the next FIX edge.
- Operand prep:
  - Signed operands: MULH, DIV, REM, and op1 of MULHSU; all others unsigned.
  - 32-bit mode: low 32 bits, sign- or zero-extended per signedness.
  - Magnitudes are taken and the result sign is recorded at accept.
- Result select:
  - MUL: low N bits of product.
  - MULH/MULHSU/MULHU: high N bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder. Remainder takes the sign of the dividend; quotient sign is the XOR of operand signs.
- 32-bit mode: the result is bits [31:0] sign-extended to XLEN. MULH/MULHSU/MULHU with i_op_32bit=1 return the MULW result.
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend (width-adjusted, sign-extended in 32-bit mode).
- Overflow (DIV/REM, dividend = most negative N-bit value, divisor = -1): quotient = dividend; remainder = 0.
- Kill:
  - i_kill in CALC or FIX -> IDLE at the next edge, no o_rd_ready, o_rd_en cleared.
  - i_kill with i_valid in IDLE -> request not accepted.
  - Kill has priority over accept and completion.
- i_valid while not o_ready: ignored. Decode must hold the request until o_ready.
- Reset mid-operation: immediate return to reset values, no result pulse.

Test Plan:
- XLEN=64, MUL op1=7, op2=-3 (0xFFFF_FFFF_FFFF_FFFD) -> o_rd_ready 66 edges after accept, o_rd_reg=0xFFFF_FFFF_FFFF_FFEB; o_busy high for 65 cycles; o_rd matches i_rd.
- MULHU op1=op2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULH same operands -> 0. MULHSU op1=-1, op2=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV -20/3 -> -6 (0xFFFF_FFFF_FFFF_FFFA); REM -20/3 -> -2; DIVU 100/7 -> 14; REMU -> 2; each 66 edges.
- DIVU op1=0x1234, op2=0 -> all ones after 2 edges; REMU -> 0x1234. DIV, 32-bit, op1=0x8000_0000, op2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 after 2 edges; REM same operands -> 0.
- DIVW 32-bit op1=0x0000_0001_0000_0064, op2=10 -> 10, latency 34 edges. MULW 0x7FFF_FFFF*2 -> 0xFFFF_FFFF_FFFF_FFFE.
- Kill at CALC cycle 10 -> no o_rd_ready, o_ready=1 next cycle; new MUL 3*5 accepted in the o_rd_ready cycle of a prior op -> 15 after 66 edges; assert i_rst mid-CALC -> all outputs at reset values immediately.

Source files
------------

// File: rtl/nnrv_exec_muldiv.sv
// Iterative RV64M/RV32M multiply/divide unit for the exec stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign fixed up at the end.
module nnrv_exec_muldiv #(
    parameter int unsigned XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [2:0]      i_op,
    input  logic            i_op_32bit,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [4:0]      i_rd,
    input  logic            i_rd_en,
    input  logic            i_kill,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_rd_en,
    output logic [4:0]      o_rd,
    output logic            o_rd_ready,
    output logic [XLEN-1:0] o_rd_reg
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                w_q, w_d;
    logic                neg_q, neg_d;
    logic                spc_q, spc_d;
    logic                rd_en_q, rd_en_d;
    logic [4:0]          rd_q, rd_d;
    logic                rdy_q, rdy_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [XLEN-1:0]     sh_q, sh_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        logic signed [31:0] t;
        t = x[31:0];
        return XLEN'(t);
    endfunction

    // Accept-side operand preparation
    logic            w_in, s1, s2, n1, n2, div_zero, min_neg, ovf, spc_in, neg_in;
    logic [2:0]      op_in;
    logic [XLEN-1:0] a_ext, b_ext, m1, m2, a_res, spc_val;

    always_comb begin
        w_in  = (XLEN == 64) && i_op_32bit;
        // W-mode high multiplies degrade to MULW
        op_in = (w_in && !i_op[2] && (i_op != 3'd0)) ? 3'd0 : i_op;
        s1    = (op_in == 3'd1) || (op_in == 3'd2) || (op_in == 3'd4) || (op_in == 3'd6);
        s2    = (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
        a_ext = w_in ? (s1 ? sext32(i_op1) : XLEN'(i_op1[31:0])) : i_op1;
        b_ext = w_in ? (s2 ? sext32(i_op2) : XLEN'(i_op2[31:0])) : i_op2;
        n1    = s1 && a_ext[XLEN-1];
        n2    = s2 && b_ext[XLEN-1];
        m1    = n1 ? -a_ext : a_ext;
        m2    = n2 ? -b_ext : b_ext;
        a_res = w_in ? sext32(i_op1) : i_op1;

        div_zero = (b_ext == '0);
        min_neg  = w_in ? (i_op1[31:0] == 32'h8000_0000)
                        : (i_op1 == {1'b1, {(XLEN-1){1'b0}}});
        ovf      = ((op_in == 3'd4) || (op_in == 3'd6)) && min_neg && (b_ext == '1);
        spc_in   = op_in[2] && (div_zero || ovf);
        if (!op_in[1])
            spc_val = div_zero ? '1 : a_res;
        else
            spc_val = div_zero ? a_res : '0;
        neg_in = (op_in == 3'd6) ? n1 : (n1 ^ n2);
    end

    // Iteration datapath
    logic              top_bit;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN:0]     r2, diff;

    always_comb begin
        top_bit = w_q ? sh_q[31] : sh_q[XLEN-1];
        mul_nxt = (acc_q << 1) + (top_bit ? {{XLEN{1'b0}}, b_q} : '0);
        r2      = {acc_q[XLEN-1:0], top_bit};
        diff    = r2 - {1'b0, b_q};
    end

    // Sign correction and result select
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   q_s, r_s, raw, fin;

    always_comb begin
        prod_s = neg_q ? -acc_q : acc_q;
        q_s    = neg_q ? -sh_q : sh_q;
        r_s    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        case (op_q)
            3'd0:       raw = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       raw = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: raw = q_s;
            default:    raw = r_s;
        endcase
        if (spc_q)
            fin = acc_q[XLEN-1:0];
        else
            fin = w_q ? sext32(raw) : raw;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        w_d     = w_q;
        neg_d   = neg_q;
        spc_d   = spc_q;
        rd_en_d = rd_en_q;
        rd_d    = rd_q;
        rdy_d   = 1'b0;
        res_d   = res_q;
        sh_d    = sh_q;
        b_d     = b_q;
        acc_d   = acc_q;

        case (state_q)
            S_IDLE: begin
                if (i_valid && !i_kill) begin
                    op_d    = op_in;
                    w_d     = w_in;
                    neg_d   = neg_in;
                    spc_d   = spc_in;
                    rd_d    = i_rd;
                    rd_en_d = i_rd_en;
                    sh_d    = m1;
                    b_d     = m2;
                    cnt_d   = w_in ? CW'(32) : CW'(XLEN);
                    if (spc_in) begin
                        acc_d   = {{XLEN{1'b0}}, spc_val};
                        state_d = S_FIX;
                    end else begin
                        acc_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (i_kill) begin
                    state_d = S_IDLE;
                    rd_en_d = 1'b0;
                end else begin
                    if (op_q[2]) begin
                        acc_d = {{XLEN{1'b0}}, diff[XLEN] ? r2[XLEN-1:0] : diff[XLEN-1:0]};
                        sh_d  = {sh_q[XLEN-2:0], ~diff[XLEN]};
                    end else begin
                        acc_d = mul_nxt;
                        sh_d  = {sh_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (i_kill) begin
                    rd_en_d = 1'b0;
                end else begin
                    res_d = fin;
                    rdy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            w_q     <= 1'b0;
            neg_q   <= 1'b0;
            spc_q   <= 1'b0;
            rd_en_q <= 1'b0;
            rd_q    <= '0;
            rdy_q   <= 1'b0;
            res_q   <= '0;
            sh_q    <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            w_q     <= w_d;
            neg_q   <= neg_d;
            spc_q   <= spc_d;
            rd_en_q <= rd_en_d;
            rd_q    <= rd_d;
            rdy_q   <= rdy_d;
            res_q   <= res_d;
            sh_q    <= sh_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign o_ready    = (state_q == S_IDLE);
    assign o_busy     = (state_q != S_IDLE);
    assign o_rd_en    = rd_en_q;
    assign o_rd       = rd_q;
    assign o_rd_ready = rdy_q;
    assign o_rd_reg   = res_q;

endmodule

// File: tb/tb_nnrv_exec_muldiv.sv
// Directed bench for nnrv_exec_muldiv (XLEN=64) with hand-computed expected results.
module tb_nnrv_exec_muldiv;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_valid = 1'b0;
    logic [2:0]      i_op = '0;
    logic            i_op_32bit = 1'b0;
    logic [XLEN-1:0] i_op1 = '0;
    logic [XLEN-1:0] i_op2 = '0;
    logic [4:0]      i_rd = '0;
    logic            i_rd_en = 1'b0;
    logic            i_kill = 1'b0;
    logic            o_ready, o_busy, o_rd_en, o_rd_ready;
    logic [4:0]      o_rd;
    logic [XLEN-1:0] o_rd_reg;

    int n_checks = 0;
    int n_pass   = 0;

    nnrv_exec_muldiv #(.XLEN(XLEN)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .i_op       (i_op),
        .i_op_32bit (i_op_32bit),
        .i_op1      (i_op1),
        .i_op2      (i_op2),
        .i_rd       (i_rd),
        .i_rd_en    (i_rd_en),
        .i_kill     (i_kill),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .o_rd_en    (o_rd_en),
        .o_rd       (o_rd),
        .o_rd_ready (o_rd_ready),
        .o_rd_reg   (o_rd_reg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Offer a request and return #1 after the accepting edge
    task automatic start_op(input logic [2:0] op, input logic w, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [4:0] rd);
        i_valid    = 1'b1;
        i_op       = op;
        i_op_32bit = w;
        i_op1      = a;
        i_op2      = b;
        i_rd       = rd;
        i_rd_en    = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Latency counts the accepting edge as edge 1
    task automatic wait_done(output int lat, output int busy);
        lat  = 1;
        busy = o_busy ? 1 : 0;
        while (!o_rd_ready && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (o_busy) busy++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp, input int exp_lat);
        int lat, busy;
        @(negedge clk);
        start_op(op, w, a, b, 5'd11);
        wait_done(lat, busy);
        check_eq({tag, "_res"}, o_rd_reg, exp);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        int lat, busy, pulses;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_flags", 64'({o_ready, o_busy, o_rd_en, o_rd_ready}), 64'b1000);
        check_eq("rst_rd", 64'(o_rd), 64'd0);
        check_eq("rst_rd_reg", o_rd_reg, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // MUL 7 * -3 with full timing checks
        @(negedge clk);
        start_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd17);
        check_eq("mul_rd", 64'(o_rd), 64'd17);
        check_eq("mul_rd_en", 64'(o_rd_en), 64'd1);
        check_eq("mul_ready_low", 64'(o_ready), 64'd0);
        wait_done(lat, busy);
        check_eq("mul_res", o_rd_reg, 64'hFFFF_FFFF_FFFF_FFEB);
        check_eq("mul_lat", 64'(lat), 64'd66);
        check_eq("mul_busy", 64'(busy), 64'd65);
        @(posedge clk);
        #1;
        check_eq("mul_pulse_one", 64'(o_rd_ready), 64'd0);
        check_eq("mul_hold", o_rd_reg, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op("mulhu",  3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mulh",   3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66);
        run_op("mulhsu", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("div",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
        run_op("rem",    3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("divu",   3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66);
        run_op("remu",   3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66);
        run_op("divu0",  3'd5, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run_op("remu0",  3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 2);
        run_op("divw_ovf", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2);
        run_op("remw_ovf", 3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 2);
        run_op("divw",   3'd4, 1'b1, 64'h0000_0001_0000_0064, 64'd10, 64'd10, 34);
        run_op("mulw",   3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("mulhw",  3'd1, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);

        // Kill in CALC cycle 10
        @(negedge clk);
        start_op(3'd5, 1'b0, 64'd100, 64'd7, 5'd9);
        repeat (9) @(posedge clk);
        #1;
        i_kill = 1'b1;
        @(posedge clk);
        #1;
        i_kill = 1'b0;
        check_eq("kill_ready", 64'(o_ready), 64'd1);
        check_eq("kill_rd_en", 64'(o_rd_en), 64'd0);
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            if (o_rd_ready) pulses++;
            @(posedge clk);
            #1;
        end
        check_eq("kill_no_pulse", 64'(pulses), 64'd0);

        // Kill with valid in IDLE blocks the accept
        @(negedge clk);
        i_kill = 1'b1;
        start_op(3'd0, 1'b0, 64'd3, 64'd5, 5'd2);
        i_kill = 1'b0;
        check_eq("kill_idle", 64'({o_ready, o_busy}), 64'b10);

        // Back-to-back accept in the result cycle
        @(negedge clk);
        start_op(3'd0, 1'b0, 64'd6, 64'd7, 5'd3);
        wait_done(lat, busy);
        check_eq("b2b_first", o_rd_reg, 64'd42);
        check_eq("b2b_ready", 64'(o_ready), 64'd1);
        start_op(3'd0, 1'b0, 64'd3, 64'd5, 5'd4);
        check_eq("b2b_hold", o_rd_reg, 64'd42);
        check_eq("b2b_rd", 64'(o_rd), 64'd4);
        wait_done(lat, busy);
        check_eq("b2b_res", o_rd_reg, 64'd15);
        check_eq("b2b_lat", 64'(lat), 64'd66);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        start_op(3'd0, 1'b0, 64'd3, 64'd5, 5'd7);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rstmid_flags", 64'({o_ready, o_busy, o_rd_en, o_rd_ready}), 64'b1000);
        check_eq("rstmid_rd", 64'(o_rd), 64'd0);
        check_eq("rstmid_rd_reg", o_rd_reg, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (o_rd_ready) pulses++;
        end
        check_eq("rstmid_no_pulse", 64'(pulses), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
